data_mem_param: RTL and testbench

Parametrised synchronous data memory: the successor of the 8×16 processor data memory. Width, depth and response latency are configurable, and writes take byte enables. Access is through a valid/ready request port with a fixed-latency response port. After reset the block clears itself before it accepts any request. It sits between the MEM stage and the load/store path of the processor.

---
 rtl/data_mem_pkg.sv | 36 +++
 rtl/data_mem_rsp_pipe.sv | 44 ++++
 rtl/data_mem_param.sv | 120 ++++++++++++
 tb/tb_data_mem_param.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : data_mem_pkg
//  Description : Shared constants, FSM encoding and byte-merge helper for the
//                parametrised data memory.
//  Revision    : 1.0 - initial release
// ============================================================================
package data_mem_pkg;

    localparam logic c_INIT = 1'b0;
    localparam logic c_RUN  = 1'b1;

    localparam int c_RD_LAT_MIN = 1;
    localparam int c_RD_LAT_MAX = 4;

    // Widest word the merge helper handles; callers zero-extend and truncate.
    localparam int c_MAX_DATA_W = 256;
    localparam int c_MAX_BE_W   = c_MAX_DATA_W / 8;

    function automatic logic [c_MAX_DATA_W-1:0] byte_merge(
        input logic [c_MAX_DATA_W-1:0] old_word,
        input logic [c_MAX_DATA_W-1:0] new_word,
        input logic [c_MAX_BE_W-1:0]   be
    );
        logic [c_MAX_DATA_W-1:0] w_merged;
        w_merged = old_word;
        for (int i = 0; i < c_MAX_BE_W; i++) begin
            if (be[i]) begin
                w_merged[8*i +: 8] = new_word[8*i +: 8];
            end
        end
        return w_merged;
    endfunction

endpackage
`default_nettype wire

// File: rtl/data_mem_rsp_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : data_mem_rsp_pipe
//  Description : Response delay line of STAGES registers; a plain wire when
//                STAGES is zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module data_mem_rsp_pipe #(
    parameter int STAGES = 0,
    parameter int W      = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] i_data,
    output logic [W-1:0] o_data
);

    generate
        if (STAGES == 0) begin : g_wire
            logic w_unused;
            assign w_unused = &{1'b0, clk, rst};
            assign o_data   = i_data;
        end else begin : g_regs
            logic [W-1:0] r_stage [STAGES];

            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < STAGES; i++) begin
                        r_stage[i] <= '0;
                    end
                end else begin
                    r_stage[0] <= i_data;
                    for (int i = 1; i < STAGES; i++) begin
                        r_stage[i] <= r_stage[i-1];
                    end
                end
            end

            assign o_data = r_stage[STAGES-1];
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/data_mem_param.sv
`default_nettype none
// ============================================================================
//  Module      : data_mem_param
//  Description : Parametrised synchronous data memory with byte enables,
//                self-clearing after reset and a fixed-latency response port.
//  Revision    : 1.0 - initial release
// ============================================================================
module data_mem_param
    import data_mem_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3,
    parameter int RD_LAT = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_write,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_be,
    output logic                rsp_valid,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err,
    output logic                init_done
);

    localparam int c_LAT = (RD_LAT < c_RD_LAT_MIN) ? c_RD_LAT_MIN :
                           (RD_LAT > c_RD_LAT_MAX) ? c_RD_LAT_MAX : RD_LAT;
    localparam int                c_PIPE_W = DATA_W + 2;
    localparam logic [ADDR_W:0]   c_DEPTH  = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] c_LAST   = ADDR_W'(DEPTH - 1);

    logic [DATA_W-1:0] r_mem [DEPTH];

    logic              r_state;
    logic [ADDR_W-1:0] r_cnt;
    logic              r_ready;
    logic              r_init_done;

    logic              r_s0_valid;
    logic              r_s0_err;
    logic [DATA_W-1:0] r_s0_rdata;

    logic              w_accept;
    logic              w_in_range;
    logic [DATA_W-1:0] w_merged;
    logic [c_PIPE_W-1:0] w_pipe_out;

    assign w_accept   = req_valid && r_ready;
    assign w_in_range = {1'b0, req_addr} < c_DEPTH;
    assign w_merged   = DATA_W'(byte_merge(c_MAX_DATA_W'(r_mem[req_addr]),
                                           c_MAX_DATA_W'(req_wdata),
                                           c_MAX_BE_W'(req_be)));

    // The array has no reset of its own: the INIT sweep is what clears it.
    always_ff @(posedge clk) begin
        if (r_state == c_INIT) begin
            r_mem[r_cnt] <= '0;
        end else if (w_accept && w_in_range && req_write) begin
            r_mem[req_addr] <= w_merged;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_INIT;
            r_cnt       <= '0;
            r_ready     <= 1'b0;
            r_init_done <= 1'b0;
        end else begin
            case (r_state)
                c_INIT: begin
                    if (r_cnt == c_LAST) begin
                        r_state     <= c_RUN;
                        r_cnt       <= '0;
                        r_ready     <= 1'b1;
                        r_init_done <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + ADDR_W'(1);
                    end
                end
                default: begin
                    r_state <= c_RUN;
                end
            endcase
        end
    end

    // First response stage; data and error stay zero unless a response is valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s0_valid <= 1'b0;
            r_s0_err   <= 1'b0;
            r_s0_rdata <= '0;
        end else begin
            r_s0_valid <= w_accept;
            r_s0_err   <= w_accept && !w_in_range;
            r_s0_rdata <= (w_accept && w_in_range && !req_write) ? r_mem[req_addr] : '0;
        end
    end

    data_mem_rsp_pipe #(
        .STAGES (c_LAT - 1),
        .W      (c_PIPE_W)
    ) u_rsp_pipe (
        .clk    (clk),
        .rst    (rst),
        .i_data ({r_s0_valid, r_s0_err, r_s0_rdata}),
        .o_data (w_pipe_out)
    );

    assign {rsp_valid, rsp_err, rsp_rdata} = w_pipe_out;
    assign req_ready = r_ready;
    assign init_done = r_init_done;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_param.sv
`default_nettype none
// ============================================================================
//  Module      : tb_data_mem_param
//  Description : Self-checking bench: a DEPTH=8/RD_LAT=1 and a DEPTH=6/RD_LAT=3
//                instance share one request stream and one reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_data_mem_param;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_write;
    logic [2:0]  req_addr;
    logic [15:0] req_wdata;
    logic [1:0]  req_be;

    logic        rdy_a, vld_a, err_a, done_a;
    logic [15:0] rd_a;
    logic        rdy_b, vld_b, err_b, done_b;
    logic [15:0] rd_b;

    always #5 clk = ~clk;

    data_mem_param #(.DATA_W(16), .DEPTH(8), .ADDR_W(3), .RD_LAT(1)) u_dut_a (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy_a),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_be(req_be), .rsp_valid(vld_a), .rsp_rdata(rd_a), .rsp_err(err_a),
        .init_done(done_a)
    );

    data_mem_param #(.DATA_W(16), .DEPTH(6), .ADDR_W(3), .RD_LAT(3)) u_dut_b (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy_b),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_be(req_be), .rsp_valid(vld_b), .rsp_rdata(rd_b), .rsp_err(err_b),
        .init_done(done_b)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: word arrays plus a schedule of responses keyed by due cycle.
    logic [15:0] mm [2][8];
    bit          mrdy [2];
    int          icnt [2];
    bit          sv [2][8];
    bit          se [2][8];
    logic [15:0] sd [2][8];
    bit          ev [2];
    bit          ee [2];
    logic [15:0] ed [2];
    int          cyc = 0;

    bit          cap_on = 1'b0;
    logic [15:0] cap_d [2][16];
    bit          cap_e [2][16];
    int          cap_n [2];

    always @(posedge clk) begin
        int dep, lat, slot;
        cyc++;
        for (int d = 0; d < 2; d++) begin
            dep = (d == 0) ? 8 : 6;
            lat = (d == 0) ? 1 : 3;
            if (rst) begin
                for (int i = 0; i < 8; i++) begin
                    sv[d][i] = 1'b0;
                    mm[d][i] = 16'h0;
                end
                mrdy[d] = 1'b0;
                icnt[d] = 0;
            end else begin
                if (req_valid && mrdy[d]) begin
                    slot = (cyc + lat - 1) % 8;
                    sv[d][slot] = 1'b1;
                    se[d][slot] = 1'b0;
                    sd[d][slot] = 16'h0;
                    if (int'(req_addr) >= dep) begin
                        se[d][slot] = 1'b1;
                    end else if (req_write) begin
                        for (int b = 0; b < 2; b++)
                            if (req_be[b]) mm[d][req_addr][8*b +: 8] = req_wdata[8*b +: 8];
                    end else begin
                        sd[d][slot] = mm[d][req_addr];
                    end
                end
                if (!mrdy[d]) begin
                    icnt[d]++;
                    if (icnt[d] == dep) mrdy[d] = 1'b1;
                end
            end
            ev[d] = sv[d][cyc % 8];
            ee[d] = ev[d] ? se[d][cyc % 8] : 1'b0;
            ed[d] = ev[d] ? sd[d][cyc % 8] : 16'h0;
            sv[d][cyc % 8] = 1'b0;
        end
        #1;
        chk("A req_ready", rdy_a, mrdy[0]);
        chk("A init_done", done_a, mrdy[0]);
        chk("A rsp_valid", vld_a, ev[0]);
        chk("A rsp_err", err_a, ee[0]);
        chk("A rsp_rdata", rd_a, ed[0]);
        chk("B req_ready", rdy_b, mrdy[1]);
        chk("B init_done", done_b, mrdy[1]);
        chk("B rsp_valid", vld_b, ev[1]);
        chk("B rsp_err", err_b, ee[1]);
        chk("B rsp_rdata", rd_b, ed[1]);
        if (cap_on) begin
            if (vld_a && cap_n[0] < 16) begin
                cap_d[0][cap_n[0]] = rd_a; cap_e[0][cap_n[0]] = err_a;
            end
            if (vld_b && cap_n[1] < 16) begin
                cap_d[1][cap_n[1]] = rd_b; cap_e[1][cap_n[1]] = err_b;
            end
            if (vld_a) cap_n[0]++;
            if (vld_b) cap_n[1]++;
        end
    end

    task automatic issue(input bit w, input logic [2:0] a, input logic [15:0] d, input logic [1:0] be);
        @(negedge clk);
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        req_be    = be;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            req_valid = 1'b0;
        end
    endtask

    typedef struct {
        bit          w;
        logic [2:0]  a;
        logic [15:0] d;
        logic [1:0]  be;
        logic [15:0] xa;
        bit          ea;
        logic [15:0] xb;
        bit          eb;
    } vec_t;

    vec_t tbl [12];

    initial begin
        int ka, kb;
        rst = 1'b1; req_valid = 1'b0; req_write = 1'b0;
        req_addr = 3'd0; req_wdata = 16'h0; req_be = 2'b00;
        cap_n[0] = 0; cap_n[1] = 0;

        tbl[0]  = '{1'b1, 3'd3, 16'h1234, 2'b11, 16'h0000, 1'b0, 16'h0000, 1'b0};
        tbl[1]  = '{1'b0, 3'd3, 16'h0000, 2'b00, 16'h1234, 1'b0, 16'h1234, 1'b0};
        tbl[2]  = '{1'b1, 3'd2, 16'hABCD, 2'b11, 16'h0000, 1'b0, 16'h0000, 1'b0};
        tbl[3]  = '{1'b1, 3'd2, 16'h00EF, 2'b01, 16'h0000, 1'b0, 16'h0000, 1'b0};
        tbl[4]  = '{1'b0, 3'd2, 16'h0000, 2'b00, 16'hABEF, 1'b0, 16'hABEF, 1'b0};
        tbl[5]  = '{1'b1, 3'd7, 16'h5555, 2'b11, 16'h0000, 1'b0, 16'h0000, 1'b1};
        tbl[6]  = '{1'b0, 3'd7, 16'h0000, 2'b00, 16'h5555, 1'b0, 16'h0000, 1'b1};
        tbl[7]  = '{1'b1, 3'd5, 16'hBEEF, 2'b10, 16'h0000, 1'b0, 16'h0000, 1'b0};
        tbl[8]  = '{1'b0, 3'd5, 16'h0000, 2'b00, 16'hBE00, 1'b0, 16'hBE00, 1'b0};
        tbl[9]  = '{1'b1, 3'd4, 16'hFFFF, 2'b00, 16'h0000, 1'b0, 16'h0000, 1'b0};
        tbl[10] = '{1'b0, 3'd4, 16'h0000, 2'b00, 16'h0000, 1'b0, 16'h0000, 1'b0};
        tbl[11] = '{1'b0, 3'd6, 16'h0000, 2'b00, 16'h0000, 1'b0, 16'h0000, 1'b1};

        // Reset for two edges, then count edges until each instance is ready.
        repeat (2) @(negedge clk);
        rst = 1'b0;
        ka = 0; kb = 0;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk); #2;
            if (rdy_a && ka == 0) ka = k;
            if (rdy_b && kb == 0) kb = k;
        end
        chk("A init edges", ka, 8);
        chk("B init edges", kb, 6);

        for (int a = 0; a < 8; a++) issue(1'b0, 3'(a), 16'h0, 2'b00);
        idle(4);

        cap_on = 1'b1;
        for (int i = 0; i < 12; i++) issue(tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].be);
        idle(5);
        cap_on = 1'b0;
        chk("A table rsp count", cap_n[0], 12);
        chk("B table rsp count", cap_n[1], 12);
        for (int i = 0; i < 12; i++) begin
            if (i < cap_n[0]) begin
                chk($sformatf("A tbl%0d rdata", i), cap_d[0][i], tbl[i].xa);
                chk($sformatf("A tbl%0d err", i), cap_e[0][i], tbl[i].ea);
            end
            if (i < cap_n[1]) begin
                chk($sformatf("B tbl%0d rdata", i), cap_d[1][i], tbl[i].xb);
                chk($sformatf("B tbl%0d err", i), cap_e[1][i], tbl[i].eb);
            end
        end

        // Back-to-back reads through the three-cycle instance.
        issue(1'b1, 3'd0, 16'h0045, 2'b11);
        issue(1'b1, 3'd1, 16'h0006, 2'b11);
        issue(1'b1, 3'd2, 16'h0009, 2'b11);
        idle(4);
        issue(1'b0, 3'd0, 16'h0, 2'b00);
        @(posedge clk); #2;
        chk("pipe E0 B valid", vld_b, 1'b0);
        chk("pipe E0 A valid", vld_a, 1'b1);
        chk("pipe E0 A rdata", rd_a, 16'h0045);
        issue(1'b0, 3'd1, 16'h0, 2'b00);
        @(posedge clk); #2;
        chk("pipe E1 B valid", vld_b, 1'b0);
        issue(1'b0, 3'd2, 16'h0, 2'b00);
        @(posedge clk); #2;
        chk("pipe E2 B valid", vld_b, 1'b1);
        chk("pipe E2 B rdata", rd_b, 16'h0045);
        idle(1);
        @(posedge clk); #2;
        chk("pipe E3 B valid", vld_b, 1'b1);
        chk("pipe E3 B rdata", rd_b, 16'h0006);
        @(posedge clk); #2;
        chk("pipe E4 B valid", vld_b, 1'b1);
        chk("pipe E4 B rdata", rd_b, 16'h0009);
        @(posedge clk); #2;
        chk("pipe E5 B valid", vld_b, 1'b0);

        // Reset the cycle after a read is accepted: its response must vanish.
        issue(1'b0, 3'd1, 16'h0, 2'b00);
        @(posedge clk); #2;
        chk("midrst E0 B valid", vld_b, 1'b0);
        @(negedge clk);
        rst = 1'b1; req_valid = 1'b0;
        @(posedge clk); #2;
        chk("midrst E1 B valid", vld_b, 1'b0);
        chk("midrst E1 B ready", rdy_b, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #2;
        chk("midrst E2 B valid", vld_b, 1'b0);
        idle(9);
        for (int a = 0; a < 8; a++) issue(1'b0, 3'(a), 16'h0, 2'b00);
        idle(4);

        // Random traffic with occasional resets.
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            rst       = ($urandom_range(0, 99) == 0);
            req_valid = $urandom_range(0, 3) != 0;
            req_write = $urandom_range(0, 1) == 1;
            req_addr  = 3'($urandom_range(0, 7));
            req_wdata = 16'($urandom);
            req_be    = 2'($urandom_range(0, 3));
        end
        @(negedge clk);
        rst = 1'b0;
        idle(12);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
